ysyx_22040386_mem_arbiter: RTL and testbench

Single-port memory arbiter between instruction fetch (IF, read-only) and the MEM stage (load/store). It sits between the pipeline and the shared memory interface. It grants one requester at a time, registers the granted request and drives it onto the memory port with a valid/ready handshake. It then routes the single outstanding response back to the owner. The MEM stage has fixed priority; IF responses can be cancelled by a pipeline flush.

---
 rtl/ysyx_22040386_mem_arbiter_if.sv | 51 +++++
 rtl/ysyx_22040386_mem_arbiter.sv | 96 +++++++++
 tb/tb_ysyx_22040386_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040386_mem_arbiter_if.sv
// ysyx_22040386_mem_arbiter_if: pipeline (IF/MEM) and shared-memory signals of the memory arbiter.
interface ysyx_22040386_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                i_ARB_if_req_valid;
    logic [ADDR_W-1:0]   i_ARB_if_addr;
    logic                o_ARB_if_req_ready;
    logic                o_ARB_if_resp_valid;
    logic [DATA_W-1:0]   o_ARB_if_rdata;
    logic                i_ARB_mem_req_valid;
    logic                i_ARB_mem_wen;
    logic [ADDR_W-1:0]   i_ARB_mem_addr;
    logic [DATA_W-1:0]   i_ARB_mem_wdata;
    logic [DATA_W/8-1:0] i_ARB_mem_wmask;
    logic                o_ARB_mem_req_ready;
    logic                o_ARB_mem_resp_valid;
    logic [DATA_W-1:0]   o_ARB_mem_rdata;
    logic                i_ARB_flush;
    logic                o_ARB_bus_valid;
    logic                i_ARB_bus_ready;
    logic                o_ARB_bus_wen;
    logic [ADDR_W-1:0]   o_ARB_bus_addr;
    logic [DATA_W-1:0]   o_ARB_bus_wdata;
    logic [DATA_W/8-1:0] o_ARB_bus_wmask;
    logic                i_ARB_bus_resp_valid;
    logic [DATA_W-1:0]   i_ARB_bus_rdata;
    logic                o_ARB_busy;

    modport slave (
        input  i_ARB_if_req_valid, i_ARB_if_addr,
        output o_ARB_if_req_ready, o_ARB_if_resp_valid, o_ARB_if_rdata,
        input  i_ARB_mem_req_valid, i_ARB_mem_wen, i_ARB_mem_addr, i_ARB_mem_wdata, i_ARB_mem_wmask,
        output o_ARB_mem_req_ready, o_ARB_mem_resp_valid, o_ARB_mem_rdata,
        input  i_ARB_flush,
        output o_ARB_bus_valid, o_ARB_bus_wen, o_ARB_bus_addr, o_ARB_bus_wdata, o_ARB_bus_wmask,
        input  i_ARB_bus_ready, i_ARB_bus_resp_valid, i_ARB_bus_rdata,
        output o_ARB_busy
    );

    modport master (
        output i_ARB_if_req_valid, i_ARB_if_addr,
        input  o_ARB_if_req_ready, o_ARB_if_resp_valid, o_ARB_if_rdata,
        output i_ARB_mem_req_valid, i_ARB_mem_wen, i_ARB_mem_addr, i_ARB_mem_wdata, i_ARB_mem_wmask,
        input  o_ARB_mem_req_ready, o_ARB_mem_resp_valid, o_ARB_mem_rdata,
        output i_ARB_flush,
        input  o_ARB_bus_valid, o_ARB_bus_wen, o_ARB_bus_addr, o_ARB_bus_wdata, o_ARB_bus_wmask,
        output i_ARB_bus_ready, i_ARB_bus_resp_valid, i_ARB_bus_rdata,
        input  o_ARB_busy
    );
endinterface

// File: rtl/ysyx_22040386_mem_arbiter.sv
// ysyx_22040386_mem_arbiter: single-outstanding IF/MEM arbiter onto one memory port, MEM has priority.
// Define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX consecutive MEM grants.
module ysyx_22040386_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input logic                       i_ARB_clk,
    input logic                       i_ARB_rst,
    ysyx_22040386_mem_arbiter_if.slave arb
);
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;
    localparam logic [1:0] O_NONE = 2'd0, O_IF = 2'd1, O_MEM = 2'd2;

    logic [1:0]          state, state_nxt, owner;
    logic                drop, req_wen;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata, if_rdata, mem_rdata;
    logic [DATA_W/8-1:0] req_wmask;
    logic                idle, arb_en, if_ok, force_if, mem_gnt, if_gnt, resp_hit;

    assign idle     = state == S_IDLE;
    assign arb_en   = idle && !i_ARB_rst;
    assign if_ok    = arb.i_ARB_if_req_valid && !arb.i_ARB_flush;
    assign mem_gnt  = arb_en && arb.i_ARB_mem_req_valid && !(force_if && if_ok);
    assign if_gnt   = arb_en && if_ok && !mem_gnt;
    // A response may arrive together with bus_ready, skipping WAIT.
    assign resp_hit = arb.i_ARB_bus_resp_valid &&
                      (state == S_WAIT || (state == S_REQ && arb.i_ARB_bus_ready));

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_MAX < 8) ? 3 : $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;
    assign force_if = starve_cnt >= CNT_W'(STARVE_MAX);
    always_ff @(posedge i_ARB_clk)
        if (i_ARB_rst || if_gnt)
            starve_cnt <= '0;
        else if (mem_gnt && arb.i_ARB_if_req_valid && !force_if)
            starve_cnt <= starve_cnt + 1'b1;
`else
    assign force_if = STARVE_MAX < 0;
`endif

    always_comb
        state_nxt = idle             ? ((mem_gnt || if_gnt) ? S_REQ : S_IDLE)
                  : state == S_REQ   ? (arb.i_ARB_bus_ready ? (resp_hit ? S_RESP : S_WAIT) : S_REQ)
                  : state == S_WAIT  ? (resp_hit ? S_RESP : S_WAIT)
                  : S_IDLE;

    always_ff @(posedge i_ARB_clk) begin
        if (i_ARB_rst) begin
            state     <= S_IDLE;
            owner     <= O_NONE;
            drop      <= 1'b0;
            req_wen   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            owner <= mem_gnt ? O_MEM : if_gnt ? O_IF : (state == S_RESP) ? O_NONE : owner;
            // Drop is sticky through REQ/WAIT and falls away as RESP returns to IDLE.
            drop  <= (state == S_REQ || state == S_WAIT) && owner == O_IF && (drop || arb.i_ARB_flush);
            if (mem_gnt) begin
                req_wen   <= arb.i_ARB_mem_wen;
                req_addr  <= arb.i_ARB_mem_addr;
                req_wdata <= arb.i_ARB_mem_wdata;
                req_wmask <= arb.i_ARB_mem_wen ? arb.i_ARB_mem_wmask : '0;
            end else if (if_gnt) begin
                req_wen   <= 1'b0;
                req_addr  <= arb.i_ARB_if_addr;
                req_wdata <= '0;
                req_wmask <= '0;
            end
            if (resp_hit && owner == O_MEM)
                mem_rdata <= req_wen ? '0 : arb.i_ARB_bus_rdata;
            if (resp_hit && owner == O_IF && !drop && !arb.i_ARB_flush)
                if_rdata <= arb.i_ARB_bus_rdata;
        end
    end

    assign arb.o_ARB_mem_req_ready  = mem_gnt;
    assign arb.o_ARB_if_req_ready   = if_gnt;
    assign arb.o_ARB_bus_valid      = state == S_REQ;
    assign arb.o_ARB_bus_wen        = req_wen;
    assign arb.o_ARB_bus_addr       = req_addr;
    assign arb.o_ARB_bus_wdata      = req_wdata;
    assign arb.o_ARB_bus_wmask      = req_wmask;
    assign arb.o_ARB_if_resp_valid  = state == S_RESP && owner == O_IF && !drop;
    assign arb.o_ARB_mem_resp_valid = state == S_RESP && owner == O_MEM;
    assign arb.o_ARB_if_rdata       = if_rdata;
    assign arb.o_ARB_mem_rdata      = mem_rdata;
    assign arb.o_ARB_busy           = !idle;
endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// tb_ysyx_22040386_mem_arbiter: directed checks of grant order, bus handshake, flush drop and starvation.
module tb_ysyx_22040386_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic exp_if;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22040386_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) arb ();

    ysyx_22040386_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
        .i_ARB_clk (clk),
        .i_ARB_rst (rst),
        .arb       (arb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after a grant (arbiter in REQ); returns settled in RESP.
    task automatic bus_xact(input int rdy_dly, input int resp_dly, input logic [63:0] rd,
                            input logic e_wen, input logic [63:0] e_addr, input logic [63:0] e_wdata,
                            input logic [7:0] e_wmask);
        for (int i = 0; i <= rdy_dly; i++) begin
            arb.i_ARB_bus_ready      = (i == rdy_dly);
            arb.i_ARB_bus_resp_valid = (i == rdy_dly) && (resp_dly == 0);
            arb.i_ARB_bus_rdata      = rd;
            #1;
            chk("req_bus_valid", {63'd0, arb.o_ARB_bus_valid}, 64'd1);
            chk("req_bus_wen", {63'd0, arb.o_ARB_bus_wen}, {63'd0, e_wen});
            chk("req_bus_addr", arb.o_ARB_bus_addr, e_addr);
            chk("req_bus_wdata", arb.o_ARB_bus_wdata, e_wdata);
            chk("req_bus_wmask", {56'd0, arb.o_ARB_bus_wmask}, {56'd0, e_wmask});
            step;
        end
        arb.i_ARB_bus_ready      = 1'b0;
        arb.i_ARB_bus_resp_valid = 1'b0;
        for (int i = 1; i <= resp_dly; i++) begin
            arb.i_ARB_bus_resp_valid = (i == resp_dly);
            #1;
            chk("wait_bus_valid", {63'd0, arb.o_ARB_bus_valid}, 64'd0);
            step;
        end
        arb.i_ARB_bus_resp_valid = 1'b0;
        #1;
        chk("resp_busy", {63'd0, arb.o_ARB_busy}, 64'd1);
    endtask

    initial begin
        arb.i_ARB_if_req_valid   = 1'b0;
        arb.i_ARB_if_addr        = '0;
        arb.i_ARB_mem_req_valid  = 1'b0;
        arb.i_ARB_mem_wen        = 1'b0;
        arb.i_ARB_mem_addr       = '0;
        arb.i_ARB_mem_wdata      = '0;
        arb.i_ARB_mem_wmask      = '0;
        arb.i_ARB_flush          = 1'b0;
        arb.i_ARB_bus_ready      = 1'b0;
        arb.i_ARB_bus_resp_valid = 1'b0;
        arb.i_ARB_bus_rdata      = '0;
        step;
        step;
        rst = 1'b0;
        #1;
        chk("rst_busy", {63'd0, arb.o_ARB_busy}, 64'd0);
        chk("rst_bus_valid", {63'd0, arb.o_ARB_bus_valid}, 64'd0);
        chk("rst_if_rdata", arb.o_ARB_if_rdata, 64'd0);

        // Reset in the middle of WAIT, then a stale response in IDLE.
        arb.i_ARB_if_req_valid = 1'b1;
        arb.i_ARB_if_addr      = 64'h100;
        #1;
        chk("t1_if_ready", {63'd0, arb.o_ARB_if_req_ready}, 64'd1);
        step;
        arb.i_ARB_if_req_valid = 1'b0;
        arb.i_ARB_bus_ready    = 1'b1;
        step;
        arb.i_ARB_bus_ready    = 1'b0;
        #1;
        chk("t1_wait_busy", {63'd0, arb.o_ARB_busy}, 64'd1);
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
        arb.i_ARB_bus_resp_valid = 1'b1;
        arb.i_ARB_bus_rdata      = 64'hFFFF_0000_FFFF_0000;
        #1;
        chk("t1_busy", {63'd0, arb.o_ARB_busy}, 64'd0);
        chk("t1_bus_addr", arb.o_ARB_bus_addr, 64'd0);
        step;
        arb.i_ARB_bus_resp_valid = 1'b0;
        #1;
        chk("t1_if_resp", {63'd0, arb.o_ARB_if_resp_valid}, 64'd0);
        chk("t1_mem_resp", {63'd0, arb.o_ARB_mem_resp_valid}, 64'd0);
        chk("t1_if_rdata", arb.o_ARB_if_rdata, 64'd0);
        chk("t1_idle", {63'd0, arb.o_ARB_busy}, 64'd0);

        // Plain IF read, response two cycles after the bus handshake.
        arb.i_ARB_if_req_valid = 1'b1;
        arb.i_ARB_if_addr      = 64'h8000_0000;
        #1;
        chk("t2_if_ready", {63'd0, arb.o_ARB_if_req_ready}, 64'd1);
        chk("t2_mem_ready", {63'd0, arb.o_ARB_mem_req_ready}, 64'd0);
        step;
        arb.i_ARB_if_req_valid = 1'b0;
        bus_xact(0, 2, 64'h0000_0013_0000_0093, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
        chk("t2_if_resp", {63'd0, arb.o_ARB_if_resp_valid}, 64'd1);
        chk("t2_if_rdata", arb.o_ARB_if_rdata, 64'h0000_0013_0000_0093);
        chk("t2_mem_resp", {63'd0, arb.o_ARB_mem_resp_valid}, 64'd0);
        step;
        chk("t2_if_resp_end", {63'd0, arb.o_ARB_if_resp_valid}, 64'd0);
        chk("t2_if_rdata_hold", arb.o_ARB_if_rdata, 64'h0000_0013_0000_0093);

        // Simultaneous requests: MEM write first, then IF.
        arb.i_ARB_if_req_valid  = 1'b1;
        arb.i_ARB_if_addr       = 64'h8000_0004;
        arb.i_ARB_mem_req_valid = 1'b1;
        arb.i_ARB_mem_wen       = 1'b1;
        arb.i_ARB_mem_addr      = 64'h8000_0100;
        arb.i_ARB_mem_wdata     = 64'hDEAD_BEEF;
        arb.i_ARB_mem_wmask     = 8'h0F;
        #1;
        chk("t3_mem_ready", {63'd0, arb.o_ARB_mem_req_ready}, 64'd1);
        chk("t3_if_ready", {63'd0, arb.o_ARB_if_req_ready}, 64'd0);
        step;
        arb.i_ARB_mem_req_valid = 1'b0;
        bus_xact(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0100, 64'hDEAD_BEEF, 8'h0F);
        chk("t3_mem_resp", {63'd0, arb.o_ARB_mem_resp_valid}, 64'd1);
        chk("t3_mem_rdata_wr", arb.o_ARB_mem_rdata, 64'd0);
        chk("t3_if_resp", {63'd0, arb.o_ARB_if_resp_valid}, 64'd0);
        chk("t3_if_ready_resp", {63'd0, arb.o_ARB_if_req_ready}, 64'd0);
        step;
        chk("t3_if_ready_idle", {63'd0, arb.o_ARB_if_req_ready}, 64'd1);
        step;
        arb.i_ARB_if_req_valid = 1'b0;
        bus_xact(0, 0, 64'h55, 1'b0, 64'h8000_0004, 64'd0, 8'h00);
        chk("t3_if_resp2", {63'd0, arb.o_ARB_if_resp_valid}, 64'd1);
        chk("t3_if_rdata2", arb.o_ARB_if_rdata, 64'h55);
        step;

        // MEM read with bus_ready held low five cycles; read mask must be zero.
        arb.i_ARB_mem_req_valid = 1'b1;
        arb.i_ARB_mem_wen       = 1'b0;
        arb.i_ARB_mem_addr      = 64'h8000_0200;
        arb.i_ARB_mem_wdata     = 64'd0;
        arb.i_ARB_mem_wmask     = 8'hFF;
        #1;
        chk("t4_mem_ready", {63'd0, arb.o_ARB_mem_req_ready}, 64'd1);
        step;
        arb.i_ARB_mem_req_valid = 1'b0;
        bus_xact(5, 0, 64'hCAFE_F00D_0000_0001, 1'b0, 64'h8000_0200, 64'd0, 8'h00);
        chk("t4_mem_resp", {63'd0, arb.o_ARB_mem_resp_valid}, 64'd1);
        chk("t4_mem_rdata", arb.o_ARB_mem_rdata, 64'hCAFE_F00D_0000_0001);
        chk("t4_if_resp", {63'd0, arb.o_ARB_if_resp_valid}, 64'd0);
        step;
        chk("t4_mem_resp_end", {63'd0, arb.o_ARB_mem_resp_valid}, 64'd0);
        chk("t4_mem_rdata_hold", arb.o_ARB_mem_rdata, 64'hCAFE_F00D_0000_0001);

        // Flush: blocks an IDLE grant, and drops an outstanding IF response.
        arb.i_ARB_if_req_valid = 1'b1;
        arb.i_ARB_if_addr      = 64'h8000_0008;
        arb.i_ARB_flush        = 1'b1;
        #1;
        chk("t5_flush_no_grant", {63'd0, arb.o_ARB_if_req_ready}, 64'd0);
        step;
        arb.i_ARB_flush = 1'b0;
        #1;
        chk("t5_if_ready", {63'd0, arb.o_ARB_if_req_ready}, 64'd1);
        step;
        arb.i_ARB_if_req_valid = 1'b0;
        arb.i_ARB_bus_ready    = 1'b1;
        #1;
        chk("t5_bus_valid", {63'd0, arb.o_ARB_bus_valid}, 64'd1);
        step;
        arb.i_ARB_bus_ready = 1'b0;
        arb.i_ARB_flush     = 1'b1;
        step;
        arb.i_ARB_flush          = 1'b0;
        arb.i_ARB_bus_resp_valid = 1'b1;
        arb.i_ARB_bus_rdata      = 64'h1234;
        step;
        arb.i_ARB_bus_resp_valid = 1'b0;
        #1;
        chk("t5_dropped_resp", {63'd0, arb.o_ARB_if_resp_valid}, 64'd0);
        chk("t5_rdata_hold", arb.o_ARB_if_rdata, 64'h55);
        chk("t5_resp_busy", {63'd0, arb.o_ARB_busy}, 64'd1);
        step;
        chk("t5_idle", {63'd0, arb.o_ARB_busy}, 64'd0);
        arb.i_ARB_if_req_valid = 1'b1;
        arb.i_ARB_if_addr      = 64'h8000_000C;
        #1;
        chk("t5_next_ready", {63'd0, arb.o_ARB_if_req_ready}, 64'd1);
        step;
        arb.i_ARB_if_req_valid = 1'b0;
        bus_xact(0, 1, 64'hABCD, 1'b0, 64'h8000_000C, 64'd0, 8'h00);
        chk("t5_next_resp", {63'd0, arb.o_ARB_if_resp_valid}, 64'd1);
        chk("t5_next_rdata", arb.o_ARB_if_rdata, 64'hABCD);
        step;

        // MEM kept valid with IF pending: guard forces IF on the fifth arbitration.
        arb.i_ARB_mem_req_valid = 1'b1;
        arb.i_ARB_mem_wen       = 1'b0;
        arb.i_ARB_mem_addr      = 64'h8000_0300;
        arb.i_ARB_mem_wmask     = 8'h00;
        arb.i_ARB_if_req_valid  = 1'b1;
        arb.i_ARB_if_addr       = 64'h8000_0400;
        for (int g = 0; g < 6; g++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_if = (g == 4);
`else
            exp_if = 1'b0;
`endif
            #1;
            chk($sformatf("t6_if_ready_%0d", g), {63'd0, arb.o_ARB_if_req_ready}, {63'd0, exp_if});
            chk($sformatf("t6_mem_ready_%0d", g), {63'd0, arb.o_ARB_mem_req_ready}, {63'd0, !exp_if});
            step;
            if (exp_if) arb.i_ARB_if_req_valid = 1'b0;
            arb.i_ARB_bus_ready      = 1'b1;
            arb.i_ARB_bus_resp_valid = 1'b1;
            arb.i_ARB_bus_rdata      = 64'(g);
            step;
            arb.i_ARB_bus_ready      = 1'b0;
            arb.i_ARB_bus_resp_valid = 1'b0;
            #1;
            chk($sformatf("t6_if_resp_%0d", g), {63'd0, arb.o_ARB_if_resp_valid}, {63'd0, exp_if});
            step;
        end
        arb.i_ARB_mem_req_valid = 1'b0;
        arb.i_ARB_if_req_valid  = 1'b0;
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
